// File: rtl/vga_timing_gen_pkg.sv
// Shared types and helpers for the VGA raster timing generator.
package vga_timing_gen_pkg;

  // Run-time timing mode selector.
  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } mode_e;

  // Total period of one raster axis in pixels (or lines).
  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: position counter with wrap, active-area flag and sync window.
module vga_timing_gen_axis_counter #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_i,
  input  logic [CW-1:0] tot_m1_i,
  input  logic [CW-1:0] act_i,
  input  logic [CW-1:0] sync_start_i,
  input  logic [CW-1:0] sync_end_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          active_o,
  output logic          sync_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Greater-or-equal keeps the counter bounded even if limits ever shrink under it.
  assign wrap_o   = (cnt_q >= tot_m1_i);
  assign active_o = (cnt_q < act_i);
  assign sync_o   = (cnt_q >= sync_start_i) && (cnt_q < sync_end_i);
  assign cnt_o    = cnt_q;

  // Next position: advance on step, returning to zero after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, frame-aligned mode latch,
// two axis counters and a registered output stage.
// The output stage loads on the pixel tick, so every output shows the
// counter position of the previous tick and all outputs stay consistent.
module vga_timing_gen #(
  parameter int CW      = 11,
  parameter int PIX_DIV = 1,
  parameter int H0_ACT  = 640,
  parameter int H0_FP   = 24,
  parameter int H0_SYNC = 40,
  parameter int H0_BP   = 128,
  parameter int V0_ACT  = 480,
  parameter int V0_FP   = 9,
  parameter int V0_SYNC = 3,
  parameter int V0_BP   = 28,
  parameter int H1_ACT  = 640,
  parameter int H1_FP   = 16,
  parameter int H1_SYNC = 96,
  parameter int H1_BP   = 48,
  parameter int V1_ACT  = 480,
  parameter int V1_FP   = 10,
  parameter int V1_SYNC = 2,
  parameter int V1_BP   = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic          wb_clk_i,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          mode_i,
  output logic          pix_en_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          mode_o
);

  import vga_timing_gen_pkg::*;

  localparam int H0_TOT = axis_total(H0_ACT, H0_FP, H0_SYNC, H0_BP);
  localparam int V0_TOT = axis_total(V0_ACT, V0_FP, V0_SYNC, V0_BP);
  localparam int H1_TOT = axis_total(H1_ACT, H1_FP, H1_SYNC, H1_BP);
  localparam int V1_TOT = axis_total(V1_ACT, V1_FP, V1_SYNC, V1_BP);

  localparam logic [CW-1:0] H0_TM1 = CW'(H0_TOT - 1);
  localparam logic [CW-1:0] H0_A   = CW'(H0_ACT);
  localparam logic [CW-1:0] H0_SS  = CW'(H0_ACT + H0_FP);
  localparam logic [CW-1:0] H0_SE  = CW'(H0_ACT + H0_FP + H0_SYNC);
  localparam logic [CW-1:0] V0_TM1 = CW'(V0_TOT - 1);
  localparam logic [CW-1:0] V0_A   = CW'(V0_ACT);
  localparam logic [CW-1:0] V0_SS  = CW'(V0_ACT + V0_FP);
  localparam logic [CW-1:0] V0_SE  = CW'(V0_ACT + V0_FP + V0_SYNC);
  localparam logic [CW-1:0] H1_TM1 = CW'(H1_TOT - 1);
  localparam logic [CW-1:0] H1_A   = CW'(H1_ACT);
  localparam logic [CW-1:0] H1_SS  = CW'(H1_ACT + H1_FP);
  localparam logic [CW-1:0] H1_SE  = CW'(H1_ACT + H1_FP + H1_SYNC);
  localparam logic [CW-1:0] V1_TM1 = CW'(V1_TOT - 1);
  localparam logic [CW-1:0] V1_A   = CW'(V1_ACT);
  localparam logic [CW-1:0] V1_SS  = CW'(V1_ACT + V1_FP);
  localparam logic [CW-1:0] V1_SE  = CW'(V1_ACT + V1_FP + V1_SYNC);

  localparam int            DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  mode_e         mode_q, mode_d;
  logic          pix_en_q, pix_en_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          mode_out_q, mode_out_d;

  logic          tick;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic [CW-1:0] h_tm1, h_a, h_ss, h_se;
  logic [CW-1:0] v_tm1, v_a, v_ss, v_se;

  assign tick = en_i && (div_q == DIV_MAX);

  // Axis limits follow the applied mode, which only changes at frame end.
  always_comb begin
    h_tm1 = H0_TM1;
    h_a   = H0_A;
    h_ss  = H0_SS;
    h_se  = H0_SE;
    v_tm1 = V0_TM1;
    v_a   = V0_A;
    v_ss  = V0_SS;
    v_se  = V0_SE;
    if (mode_q == MODE1) begin
      h_tm1 = H1_TM1;
      h_a   = H1_A;
      h_ss  = H1_SS;
      h_se  = H1_SE;
      v_tm1 = V1_TM1;
      v_a   = V1_A;
      v_ss  = V1_SS;
      v_se  = V1_SE;
    end
  end

  vga_timing_gen_axis_counter #(.CW(CW)) u_h (
    .clk          (wb_clk_i),
    .rst_n        (rst_n),
    .step_i       (tick),
    .tot_m1_i     (h_tm1),
    .act_i        (h_a),
    .sync_start_i (h_ss),
    .sync_end_i   (h_se),
    .cnt_o        (h_cnt),
    .wrap_o       (h_wrap),
    .active_o     (h_act),
    .sync_o       (h_sync)
  );

  vga_timing_gen_axis_counter #(.CW(CW)) u_v (
    .clk          (wb_clk_i),
    .rst_n        (rst_n),
    .step_i       (tick && h_wrap),
    .tot_m1_i     (v_tm1),
    .act_i        (v_a),
    .sync_start_i (v_ss),
    .sync_end_i   (v_se),
    .cnt_o        (v_cnt),
    .wrap_o       (v_wrap),
    .active_o     (v_act),
    .sync_o       (v_sync)
  );

  // Divider, mode latch and output stage next-state; all hold while en_i is low.
  always_comb begin
    div_d         = div_q;
    mode_d        = mode_q;
    pix_en_d      = tick;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    mode_out_d    = mode_out_q;
    if (en_i) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      de_d          = h_act && v_act;
      hsync_d       = h_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_sync ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      mode_out_d    = mode_q;
      if (h_wrap && v_wrap) begin
        mode_d = mode_e'(mode_i);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      div_q         <= '0;
      mode_q        <= MODE0;
      pix_en_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      mode_out_q    <= 1'b0;
    end else begin
      div_q         <= div_d;
      mode_q        <= mode_d;
      pix_en_q      <= pix_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      mode_out_q    <= mode_out_d;
    end
  end

  assign pix_en_o      = pix_en_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign mode_o        = mode_out_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: instance a uses default timing with one
// pixel per clock; instance b uses small timings with PIX_DIV=4 so whole
// frames and mode switches fit in a short run.
module tb_vga_timing_gen;

  // Clock and check bookkeeping.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a_n, en_a, mode_a;
  logic        pix_en_a, hs_a, vs_a, de_a, ls_a, fs_a, mo_a;
  logic [10:0] x_a, y_a;

  logic        rst_b_n, en_b, mode_b;
  logic        pix_en_b, hs_b, vs_b, de_b, ls_b, fs_b, mo_b;
  logic [10:0] x_b, y_b;

  vga_timing_gen u_a (
    .wb_clk_i      (clk),
    .rst_n         (rst_a_n),
    .en_i          (en_a),
    .mode_i        (mode_a),
    .pix_en_o      (pix_en_a),
    .hsync_o       (hs_a),
    .vsync_o       (vs_a),
    .de_o          (de_a),
    .x_o           (x_a),
    .y_o           (y_a),
    .line_start_o  (ls_a),
    .frame_start_o (fs_a),
    .mode_o        (mo_a)
  );

  vga_timing_gen #(
    .PIX_DIV(4),
    .H0_ACT(8), .H0_FP(2), .H0_SYNC(3), .H0_BP(3),
    .V0_ACT(4), .V0_FP(1), .V0_SYNC(2), .V0_BP(1),
    .H1_ACT(6), .H1_FP(1), .H1_SYNC(2), .H1_BP(1),
    .V1_ACT(4), .V1_FP(2), .V1_SYNC(1), .V1_BP(2)
  ) u_b (
    .wb_clk_i      (clk),
    .rst_n         (rst_b_n),
    .en_i          (en_b),
    .mode_i        (mode_b),
    .pix_en_o      (pix_en_b),
    .hsync_o       (hs_b),
    .vsync_o       (vs_b),
    .de_o          (de_b),
    .x_o           (x_b),
    .y_o           (y_b),
    .line_start_o  (ls_b),
    .frame_start_o (fs_b),
    .mode_o        (mo_b)
  );

  typedef struct {
    int   x;
    logic hs;
    logic de;
    logic ls;
    logic fs;
  } hvec_t;

  hvec_t hv[8];

  // Scoreboard compare.
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout waiting for DUT event", name);
  endtask

  // Wait (bounded) until instance a shows column x; the current sample counts.
  task automatic wait_x_a(input int x);
    int n = 0;
    while (int'(x_a) != x && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (int'(x_a) != x) timeout("wait_x_a");
  endtask

  task automatic wait_y_b(input int y);
    int n = 0;
    while (int'(y_b) != y && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (int'(y_b) != y) timeout("wait_y_b");
  endtask

  // Clocks until the next hsync falling edge of instance a or b.
  task automatic wait_hs_fall(input bit sel_b, output int n);
    logic prev;
    logic cur;
    prev = sel_b ? hs_b : hs_a;
    n = 0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      cur = sel_b ? hs_b : hs_a;
      if (prev && !cur) return;
      prev = cur;
    end
    timeout("wait_hs_fall");
    n = -1;
  endtask

  task automatic wait_ls_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ls_a && n < 2000);
    if (!ls_a) timeout("wait_ls_a");
  endtask

  task automatic wait_fs_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 2000);
    if (!fs_b) timeout("wait_fs_b");
  endtask

  // From a frame_start sample of b to the next one, counting pixel statistics.
  task automatic run_frame_b(output int cyc, output int de_px, output int vs_px, output int vs_y0);
    cyc = 0; de_px = 0; vs_px = 0; vs_y0 = -1;
    do begin
      if (pix_en_b) begin
        if (de_b) de_px++;
        if (!vs_b) begin
          vs_px++;
          if (vs_y0 < 0) vs_y0 = int'(y_b);
        end
      end
      @(negedge clk);
      cyc++;
    end while (!fs_b && cyc < 4000);
    if (!fs_b) timeout("run_frame_b");
  endtask

  initial begin
    int n, k, cyc, de_px, vs_px, vs_y0;

    hv[0] = '{x: 0,   hs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1};
    hv[1] = '{x: 639, hs: 1'b1, de: 1'b1, ls: 1'b0, fs: 1'b0};
    hv[2] = '{x: 640, hs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};
    hv[3] = '{x: 663, hs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};
    hv[4] = '{x: 664, hs: 1'b0, de: 1'b0, ls: 1'b0, fs: 1'b0};
    hv[5] = '{x: 703, hs: 1'b0, de: 1'b0, ls: 1'b0, fs: 1'b0};
    hv[6] = '{x: 704, hs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};
    hv[7] = '{x: 831, hs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0};

    rst_a_n = 1'b0; en_a = 1'b1; mode_a = 1'b0;
    rst_b_n = 1'b0; en_b = 1'b1; mode_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of instance a.
    check("rst_x", int'(x_a), 0);
    check("rst_y", int'(y_a), 0);
    check("rst_hs", int'(hs_a), 1);
    check("rst_vs", int'(vs_a), 1);
    check("rst_de", int'(de_a), 0);
    check("rst_pix_en", int'(pix_en_a), 0);
    check("rst_ls", int'(ls_a), 0);
    check("rst_fs", int'(fs_a), 0);
    check("rst_mode", int'(mo_a), 0);

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    check("a_first_fs", int'(fs_a), 1);
    check("a_first_pix_en", int'(pix_en_a), 1);

    // Line 0 decode table for mode0.
    for (int i = 0; i < 8; i++) begin
      wait_x_a(hv[i].x);
      check($sformatf("a_hs_x%0d", hv[i].x), int'(hs_a), int'(hv[i].hs));
      check($sformatf("a_de_x%0d", hv[i].x), int'(de_a), int'(hv[i].de));
      check($sformatf("a_ls_x%0d", hv[i].x), int'(ls_a), int'(hv[i].ls));
      check($sformatf("a_fs_x%0d", hv[i].x), int'(fs_a), int'(hv[i].fs));
      check($sformatf("a_y_x%0d", hv[i].x), int'(y_a), 0);
    end

    // Hsync width and period, and offset from line start.
    wait_hs_fall(1'b0, n);
    k = 0;
    while (!hs_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("a_hs_width", k, 40);
    wait_hs_fall(1'b0, n);
    check("a_hs_period", k + n, 832);
    wait_ls_a(n);
    wait_hs_fall(1'b0, n);
    check("a_ls_to_hs", n, 664);

    // Enable freeze at x=300 and resume.
    wait_x_a(300);
    en_a = 1'b0;
    repeat (100) @(negedge clk);
    check("a_hold_x", int'(x_a), 300);
    check("a_hold_pix_en", int'(pix_en_a), 0);
    check("a_hold_de", int'(de_a), 1);
    en_a = 1'b1;
    @(negedge clk);
    check("a_resume_x", int'(x_a), 301);
    check("a_resume_pix_en", int'(pix_en_a), 1);

    // Instance b: divider cadence.
    wait_fs_b(n);
    check("b_fs_x", int'(x_b), 0);
    check("b_fs_pix_en", int'(pix_en_b), 1);
    repeat (3) @(negedge clk);
    check("b_div_x_hold", int'(x_b), 0);
    check("b_div_pix_en_low", int'(pix_en_b), 0);
    @(negedge clk);
    check("b_div_x_step", int'(x_b), 1);
    check("b_div_pix_en_high", int'(pix_en_b), 1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pix_en_b) k++;
    end
    check("b_pix_en_count", k, 10);
    wait_hs_fall(1'b1, n);
    wait_hs_fall(1'b1, n);
    check("b_hs_period_m0", n, 64);

    // Full mode0 frame.
    wait_fs_b(n);
    run_frame_b(cyc, de_px, vs_px, vs_y0);
    check("b_frame_m0", cyc, 512);
    check("b_de_px_m0", de_px, 32);
    check("b_vs_px_m0", vs_px, 32);
    check("b_vs_y0_m0", vs_y0, 5);

    // Request mode1 mid-frame: current frame keeps mode0 length.
    repeat (100) @(negedge clk);
    mode_b = 1'b1;
    check("b_mode_pending", int'(mo_b), 0);
    wait_fs_b(n);
    check("b_switch_frame", 100 + n, 512);
    check("b_mode_applied", int'(mo_b), 1);
    run_frame_b(cyc, de_px, vs_px, vs_y0);
    check("b_frame_m1", cyc, 360);
    check("b_de_px_m1", de_px, 24);
    check("b_vs_px_m1", vs_px, 10);
    check("b_vs_y0_m1", vs_y0, 6);
    wait_hs_fall(1'b1, n);
    wait_hs_fall(1'b1, n);
    check("b_hs_period_m1", n, 40);

    // Toggle away and back within the frame: no change.
    mode_b = 1'b0;
    repeat (20) @(negedge clk);
    mode_b = 1'b1;
    wait_fs_b(n);
    check("b_toggle_mode", int'(mo_b), 1);
    run_frame_b(cyc, de_px, vs_px, vs_y0);
    check("b_toggle_frame", cyc, 360);

    // Back to mode0: the running mode1 frame completes first.
    mode_b = 1'b0;
    run_frame_b(cyc, de_px, vs_px, vs_y0);
    check("b_back_frame", cyc, 360);
    check("b_back_mode", int'(mo_b), 0);
    run_frame_b(cyc, de_px, vs_px, vs_y0);
    check("b_back_frame_m0", cyc, 512);

    // Reset mid-frame during vsync.
    wait_y_b(5);
    check("b_pre_rst_vs", int'(vs_b), 0);
    rst_b_n = 1'b0;
    @(negedge clk);
    check("b_rst_x", int'(x_b), 0);
    check("b_rst_y", int'(y_b), 0);
    check("b_rst_hs", int'(hs_b), 1);
    check("b_rst_vs", int'(vs_b), 1);
    check("b_rst_de", int'(de_b), 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    wait_fs_b(n);
    check("b_rst_to_fs", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
